stream_split: RTL and testbench

STREAM_SPLIT -- requirements
Module: stream_split

---
 rtl/stream_split_pkg.sv | 9 +
 rtl/stream_split_lane.sv | 35 +++
 rtl/stream_split.sv | 55 +++++
 tb/tb_stream_split.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_split_pkg.sv
// Shared constants and types for the wide-word to per-lane stream splitter.
package stream_split_pkg;

  localparam int DEFAULT_N_LANES = 13;
  localparam int DEFAULT_LANE_W  = 8;

  typedef logic [DEFAULT_LANE_W-1:0] lane_data_t;

endpackage

// File: rtl/stream_split_lane.sv
// One output lane: a single registered beat with a full flag and ready/valid handshake.
module stream_split_lane
  import stream_split_pkg::*;
#(
  parameter int LANE_W = DEFAULT_LANE_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [LANE_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [LANE_W-1:0] data,
  output logic              free
);

  logic full;

  // A reload in the same cycle as a drain keeps the lane full with no bubble.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (ready) begin
      full <= 1'b0;
    end
  end

  assign valid = full;
  assign free  = !full || ready;

endmodule

// File: rtl/stream_split.sv
// Splits each accepted wide word into N_LANES independent AXI-Stream lanes.
// Optional feature: define STREAM_SPLIT_WORD_CNT_EN to add the word_count output.
module stream_split
  import stream_split_pkg::*;
#(
  parameter int N_LANES = DEFAULT_N_LANES,
  parameter int LANE_W  = DEFAULT_LANE_W
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_LANES*LANE_W-1:0] S_AXIS_TDATA,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  output logic [N_LANES*LANE_W-1:0] M_AXIS_TDATA,
  output logic [N_LANES-1:0]        M_AXIS_TVALID,
  input  logic [N_LANES-1:0]        M_AXIS_TREADY
`ifdef STREAM_SPLIT_WORD_CNT_EN
  ,
  output logic [31:0]               word_count
`endif
);

  logic [N_LANES-1:0] lane_free;
  logic               load;

  // Combinational from M_AXIS_TREADY so a draining lane can be refilled in the same cycle.
  assign S_AXIS_TREADY = &lane_free;
  assign load          = S_AXIS_TVALID && S_AXIS_TREADY;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    stream_split_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .load      (load),
      .load_data (S_AXIS_TDATA[k*LANE_W +: LANE_W]),
      .ready     (M_AXIS_TREADY[k]),
      .valid     (M_AXIS_TVALID[k]),
      .data      (M_AXIS_TDATA[k*LANE_W +: LANE_W]),
      .free      (lane_free[k])
    );
  end

`ifdef STREAM_SPLIT_WORD_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_count <= '0;
    end else if (load) begin
      word_count <= word_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_split.sv
// Directed bench for stream_split: reset, streaming, stalled lane, random backpressure, mid-run reset.
// Define STREAM_SPLIT_WORD_CNT_EN to also exercise the word_count wrap.
module tb_stream_split;
  import stream_split_pkg::*;

  localparam int NL = 13;
  localparam int LW = 8;
  localparam int W  = NL * LW;

  logic          aclk;
  logic          aresetn;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic [NL-1:0] m_tvalid;
  logic [NL-1:0] m_tready;
`ifdef STREAM_SPLIT_WORD_CNT_EN
  logic [31:0]   word_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  stream_split #(.N_LANES(NL), .LANE_W(LW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready)
`ifdef STREAM_SPLIT_WORD_CNT_EN
    ,
    .word_count    (word_count)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] make_word(input int n);
    logic [W-1:0] w;
    for (int k = 0; k < NL; k++) w[k*LW +: LW] = 8'((n * 7 + k * 17 + 1) & 8'hFF);
    return w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < NL; k++) w[k*LW +: LW] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  lane_data_t   q[NL][$];
  logic [W-1:0] wa, wb, cur;
  logic [NL-1:0] exp_v;
  logic          exp_rdy;
  int            sent, cycles, empty_all;

  initial begin
    // ---- reset held with input valid ----
    aresetn  = 1'b0;
    s_tvalid = 1'b1;
    m_tready = '1;
    for (int k = 0; k < NL; k++) s_tdata[k*LW +: LW] = 8'(k);
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 128'(m_tvalid), 128'd0);
    chk("rst_tready", 128'(s_tready), 128'd1);
    chk("rst_tdata",  128'(m_tdata),  128'd0);

    // ---- 100 back-to-back words, all lanes ready ----
    aresetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        chk("stream_data",  128'(m_tdata),  128'(make_word(i - 1)));
        chk("stream_valid", 128'(m_tvalid), 128'({NL{1'b1}}));
      end
      s_tdata  = make_word(i);
      s_tvalid = 1'b1;
      #1;
      chk("stream_tready", 128'(s_tready), 128'd1);
      @(negedge aclk);
    end
    chk("stream_last", 128'(m_tdata), 128'(make_word(99)));
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("stream_drained", 128'(m_tvalid), 128'd0);

    // ---- lane 5 stalled for 10 cycles ----
    wa = make_word(500);
    wb = make_word(600);
    m_tready = ~(NL'(1) << 5);
    s_tdata  = wa;
    s_tvalid = 1'b1;
    #1;
    chk("stall_rdy0", 128'(s_tready), 128'd1);
    @(negedge aclk);
    chk("stall_load_v", 128'(m_tvalid), 128'({NL{1'b1}}));
    chk("stall_load_d", 128'(m_tdata),  128'(wa));
    s_tdata = wb;
    #1;
    chk("stall_rdy_lo", 128'(s_tready), 128'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("stall_v",   128'(m_tvalid), 128'(NL'(1) << 5));
      chk("stall_rdy", 128'(s_tready), 128'd0);
      chk("stall_d5",  128'(m_tdata[5*LW +: LW]), 128'(wa[5*LW +: LW]));
    end
    m_tready = '1;
    #1;
    chk("stall_release_rdy", 128'(s_tready), 128'd1);
    @(negedge aclk);
    chk("stall_next_d", 128'(m_tdata),  128'(wb));
    chk("stall_next_v", 128'(m_tvalid), 128'({NL{1'b1}}));
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("stall_drained", 128'(m_tvalid), 128'd0);

    // ---- random 50% backpressure, 1000 words, per-lane scoreboards ----
    sent   = 0;
    cycles = 0;
    cur    = rand_word();
    empty_all = 1;
    while ((sent < 1000 || empty_all == 0) && cycles < 20000) begin
      for (int k = 0; k < NL; k++) m_tready[k] = 1'($urandom_range(0, 1));
      s_tvalid = (sent < 1000);
      s_tdata  = cur;
      #1;
      exp_rdy = 1'b1;
      for (int k = 0; k < NL; k++) begin
        exp_v[k] = (q[k].size() != 0);
        if (exp_v[k] && !m_tready[k]) exp_rdy = 1'b0;
      end
      chk("rnd_valid",  128'(m_tvalid), 128'(exp_v));
      chk("rnd_tready", 128'(s_tready), 128'(exp_rdy));
      for (int k = 0; k < NL; k++) begin
        if (m_tvalid[k] && m_tready[k] && q[k].size() != 0) begin
          chk($sformatf("rnd_lane%0d", k), 128'(m_tdata[k*LW +: LW]), 128'(q[k][0]));
          void'(q[k].pop_front());
        end
      end
      if (s_tvalid && s_tready) begin
        for (int k = 0; k < NL; k++) q[k].push_back(cur[k*LW +: LW]);
        sent++;
        cur = rand_word();
      end
      empty_all = 1;
      for (int k = 0; k < NL; k++) if (q[k].size() != 0) empty_all = 0;
      @(negedge aclk);
      cycles++;
    end
    chk("rnd_sent",  128'(sent),      128'd1000);
    chk("rnd_empty", 128'(empty_all), 128'd1);
    s_tvalid = 1'b0;
    m_tready = '1;
    @(negedge aclk);
    chk("rnd_idle", 128'(m_tvalid), 128'd0);

    // ---- reset pulsed while lanes 2, 7, 11 are full ----
    m_tready = ~((NL'(1) << 2) | (NL'(1) << 7) | (NL'(1) << 11));
    s_tdata  = make_word(900);
    s_tvalid = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("mid_full3", 128'(m_tvalid), 128'((NL'(1) << 2) | (NL'(1) << 7) | (NL'(1) << 11)));
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_async_v",   128'(m_tvalid), 128'd0);
    chk("mid_async_d",   128'(m_tdata),  128'd0);
    chk("mid_async_rdy", 128'(s_tready), 128'd1);
    @(negedge aclk);
    aresetn  = 1'b1;
    m_tready = '1;
    s_tdata  = {NL{8'hAA}};
    s_tvalid = 1'b1;
    @(negedge aclk);
    chk("mid_post_d", 128'(m_tdata),  128'({NL{8'hAA}}));
    chk("mid_post_v", 128'(m_tvalid), 128'({NL{1'b1}}));
    s_tvalid = 1'b0;
    @(negedge aclk);
    chk("mid_post_drain", 128'(m_tvalid), 128'd0);

`ifdef STREAM_SPLIT_WORD_CNT_EN
    // ---- word counter wrap ----
    force dut.word_count = 32'hFFFF_FFFE;
    #1;
    release dut.word_count;
    for (int i = 0; i < 3; i++) begin
      s_tdata  = make_word(i);
      s_tvalid = 1'b1;
      @(negedge aclk);
      s_tvalid = 1'b0;
      case (i)
        0: chk("cnt_ffffffff", 128'(word_count), 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
        1: chk("cnt_wrap0",    128'(word_count), 128'd0);
        default: chk("cnt_one", 128'(word_count), 128'd1);
      endcase
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
